fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads 16-bit instructions as two bytes over a req/ack
// memory port, buffers them in a 2-entry FIFO and hands them to decode with their PC.
module fetch_unit #(
  parameter int                    WIDTH_ADDR = 16,
  parameter int                    WIDTH_BYTE = 8,
  parameter logic [WIDTH_ADDR-1:0] RESET_PC   = '0,
  parameter logic [3:0]            HLT_OPC    = 4'h0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pc_load,
  input  logic [WIDTH_ADDR-1:0]   pc_in,
  output logic                    mem_req,
  output logic [WIDTH_ADDR-1:0]   mem_addr,
  input  logic                    mem_ack,
  input  logic [WIDTH_BYTE-1:0]   mem_rdata,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic [2*WIDTH_BYTE-1:0] op,
  output logic [WIDTH_ADDR-1:0]   op_pc,
  output logic                    halted
);

  localparam int WIDTH_OP = 2 * WIDTH_BYTE;

  typedef enum logic [1:0] {IDLE, LO, HI, DRAIN} state_t;

  typedef struct packed {
    logic [WIDTH_OP-1:0]   op;
    logic [WIDTH_ADDR-1:0] pc;
  } entry_t;

  state_t                  state_q, state_d;
  logic [WIDTH_ADDR-1:0]   fetch_pc_q, fetch_pc_d;
  logic [WIDTH_BYTE-1:0]   lo_q, lo_d;
  logic                    halted_d;
  logic                    mem_req_d;
  logic [WIDTH_ADDR-1:0]   mem_addr_d;
  logic                    head_valid_d;
  entry_t                  head_q, head_d;
  logic                    tail_valid_q, tail_valid_d;
  entry_t                  tail_q, tail_d;

  logic                    pop;
  logic                    xfer;
  logic                    push;
  logic                    room;
  entry_t                  push_entry;

  assign op    = head_q.op;
  assign op_pc = head_q.pc;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    lo_d         = lo_q;
    halted_d     = halted;
    mem_req_d    = mem_req;
    mem_addr_d   = mem_addr;
    head_valid_d = op_valid;
    head_d       = head_q;
    tail_valid_d = tail_valid_q;
    tail_d       = tail_q;

    pop        = op_valid && op_ready;
    xfer       = mem_req && mem_ack;
    push       = (state_q == HI) && xfer;
    push_entry = {mem_rdata, lo_q, fetch_pc_q};

    // FIFO: pop shifts the tail into the head, then a push fills the first free slot.
    if (pop) begin
      head_valid_d = tail_valid_q;
      head_d       = tail_q;
      tail_valid_d = 1'b0;
    end
    if (push) begin
      if (!head_valid_d) begin
        head_valid_d = 1'b1;
        head_d       = push_entry;
      end else begin
        tail_valid_d = 1'b1;
        tail_d       = push_entry;
      end
    end
    room = !(head_valid_d && tail_valid_d);

    case (state_q)
      IDLE: begin
        if (!halted && room) begin
          state_d    = LO;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      LO: begin
        if (xfer) begin
          lo_d       = mem_rdata;
          mem_addr_d = fetch_pc_q + WIDTH_ADDR'(1);
          state_d    = HI;
        end
      end
      HI: begin
        if (xfer) begin
          fetch_pc_d = fetch_pc_q + WIDTH_ADDR'(2);
          if (mem_rdata[WIDTH_BYTE-1 -: 4] == HLT_OPC) begin
            halted_d  = 1'b1;
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end else if (room) begin
            mem_addr_d = fetch_pc_d;
            state_d    = LO;
          end else begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      DRAIN: begin
        // The stale byte is dropped; the real fetch starts at the redirected PC.
        if (xfer) begin
          mem_addr_d = fetch_pc_q;
          state_d    = LO;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect overrides everything above, including a same-edge push.
    if (pc_load) begin
      head_valid_d = 1'b0;
      tail_valid_d = 1'b0;
      lo_d         = '0;
      halted_d     = 1'b0;
      fetch_pc_d   = pc_in;
      mem_req_d    = 1'b1;
      if (mem_req && !mem_ack) begin
        mem_addr_d = mem_addr;
        state_d    = DRAIN;
      end else begin
        mem_addr_d = pc_in;
        state_d    = LO;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      lo_q         <= '0;
      halted       <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      op_valid     <= 1'b0;
      head_q       <= '0;
      tail_valid_q <= 1'b0;
      tail_q       <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      lo_q         <= lo_d;
      halted       <= halted_d;
      mem_req      <= mem_req_d;
      mem_addr     <= mem_addr_d;
      op_valid     <= head_valid_d;
      head_q       <= head_d;
      tail_valid_q <= tail_valid_d;
      tail_q       <= tail_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: byte memory with random wait states and an
// instruction-stream reference model built from memory contents and the start PC.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_in = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [15:0] op;
  logic [15:0] op_pc;
  logic        halted;

  logic [7:0]  mem [0:65535];
  logic [31:0] got [$];
  logic [31:0] exp_q [$];

  int total = 0;
  int bad = 0;
  int wcnt = 0;
  int wait_cur = 0;
  int fixed_wait = 0;
  bit rand_wait = 1'b0;
  int xfer_cnt = 0;
  int got_base = 0;

  fetch_unit #(
    .WIDTH_ADDR(16),
    .WIDTH_BYTE(8),
    .RESET_PC  (16'h0006),
    .HLT_OPC   (4'h0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_load  (pc_load),
    .pc_in    (pc_in),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .op_pc    (op_pc),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Memory responder: acks once the current request has waited wait_cur cycles.
  assign mem_ack   = mem_req && (wcnt >= wait_cur);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      wcnt     <= 0;
      xfer_cnt <= xfer_cnt + 1;
      wait_cur <= rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt     <= 0;
      wait_cur <= rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
    end
  end

  // Delivered instructions {op, op_pc}, recorded half a cycle before the handshake edge.
  always @(negedge clk) begin
    if (rst_n && op_valid && op_ready) got.push_back({op, op_pc});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: consecutive little-endian words from start, ending after a halt opcode.
  task automatic build_model(input logic [15:0] start, input int n);
    logic [15:0] p;
    logic [15:0] w;
    exp_q.delete();
    p = start;
    for (int i = 0; i < n; i++) begin
      w = {mem[p + 16'd1], mem[p]};
      exp_q.push_back({w, p});
      if (w[15:12] == 4'h0) break;
      p = p + 16'd2;
    end
  endtask

  task automatic load_pc(input logic [15:0] addr);
    pc_in   = addr;
    pc_load = 1'b1;
    tick();
    pc_load  = 1'b0;
    got_base = got.size();
  endtask

  task automatic wait_got(input string tag, input int target, input int budget);
    int k = 0;
    while (got.size() < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(got.size() >= target), 32'd1);
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  task automatic check_stream(input string tag, input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i),
            (base + i < got.size()) ? got[base + i] : 32'hDEAD_BEEF, exp_q[i]);
    end
  endtask

  initial begin
    int k;
    int x0;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[6]  = 8'h18; mem[7]  = 8'h01;
    mem[8]  = 8'h05; mem[9]  = 8'hC3;
    mem[10] = 8'h31; mem[11] = 8'h82;
    mem[12] = 8'h00; mem[13] = 8'h00;
    mem[16'hFFFE] = 8'h34; mem[16'hFFFF] = 8'h12;
    mem[0] = 8'h78; mem[1] = 8'h56;
    mem[16'h0200] = 8'hEE;
    for (int a = 16'h0100; a < 16'h0140; a += 2) mem[a + 1] = {4'($urandom_range(1, 15)), 4'($urandom)};
    for (int a = 16'h0040; a < 16'h0048; a += 2) mem[a + 1] = {4'($urandom_range(1, 15)), 4'($urandom)};

    // Reset values.
    tick();
    tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_op", 32'(op), 32'd0);
    check("rst_op_pc", 32'(op_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Zero-wait fetch from RESET_PC through to the halt instruction.
    rst_n    = 1'b1;
    got_base = got.size();
    tick();
    check("e0_mem_req", 32'(mem_req), 32'd1);
    check("e0_mem_addr", 32'(mem_addr), 32'h0006);
    check("e0_op_valid", 32'(op_valid), 32'd0);
    tick();
    check("e1_op_valid", 32'(op_valid), 32'd0);
    check("e1_mem_addr", 32'(mem_addr), 32'h0007);
    tick();
    check("e2_op_valid", 32'(op_valid), 32'd1);
    check("e2_head", {op, op_pc}, {16'h0118, 16'h0006});
    wait_halt("boot_halt", 40);
    check("boot_halt_req", 32'(mem_req), 32'd0);
    repeat (3) tick();
    build_model(16'h0006, 8);
    check("boot_count", 32'(got.size() - got_base), 32'(exp_q.size()));
    check_stream("boot", got_base);

    // Decode stalled: exactly two instructions buffered, then order preserved.
    rand_wait = 1'b1;
    op_ready  = 1'b0;
    load_pc(16'h0100);
    x0 = xfer_cnt;
    k  = 0;
    while (mem_req && k < 60) begin
      tick();
      k++;
    end
    repeat (4) tick();
    build_model(16'h0100, 8);
    check("stall_req_low", 32'(mem_req), 32'd0);
    check("stall_bytes", 32'(xfer_cnt - x0), 32'd4);
    check("stall_none_out", 32'(got.size() - got_base), 32'd0);
    check("stall_head", {op, op_pc}, exp_q[0]);
    op_ready = 1'b1;
    wait_got("stall_wait", got_base + 8, 200);
    check_stream("stall", got_base);

    // Park in halt so the next test starts with no request outstanding.
    rand_wait  = 1'b0;
    fixed_wait = 0;
    load_pc(16'h000C);
    wait_halt("park_halt", 40);

    // Redirect while a low-byte request waits three cycles for its ack.
    fixed_wait = 3;
    tick();
    load_pc(16'h0200);
    tick();
    load_pc(16'h0040);
    check("drain_req", 32'(mem_req), 32'd1);
    check("drain_addr_a", 32'(mem_addr), 32'h0200);
    check("drain_op_valid", 32'(op_valid), 32'd0);
    tick();
    check("drain_addr_b", 32'(mem_addr), 32'h0200);
    tick();
    check("redir_addr", 32'(mem_addr), 32'h0040);
    check("redir_req", 32'(mem_req), 32'd1);
    build_model(16'h0040, 3);
    wait_got("redir_wait", got_base + 3, 150);
    check_stream("redir", got_base);

    // Address wrap-around, even and odd.
    fixed_wait = 0;
    load_pc(16'hFFFE);
    wait_got("wrap_wait", got_base + 2, 60);
    check("wrap_op0", got[got_base], {16'h1234, 16'hFFFE});
    check("wrap_op1", got[got_base + 1], {16'h5678, 16'h0000});
    load_pc(16'hFFFF);
    wait_got("odd_wait", got_base + 1, 60);
    check("odd_op0", got[got_base], {16'h7812, 16'hFFFF});

    // Redirect out of halt, then a redirect on the same edge as a handshake.
    load_pc(16'h000C);
    wait_halt("halt2", 40);
    op_ready = 1'b0;
    load_pc(16'h0008);
    check("unhalt", 32'(halted), 32'd0);
    check("unhalt_req", 32'(mem_req), 32'd1);
    check("unhalt_addr", 32'(mem_addr), 32'h0008);
    k = 0;
    while (mem_req && k < 40) begin
      tick();
      k++;
    end
    check("full_head", {op, op_pc}, {16'hC305, 16'h0008});
    got_base = got.size();
    op_ready = 1'b1;
    pc_in    = 16'h0040;
    pc_load  = 1'b1;
    tick();
    pc_load = 1'b0;
    check("hs_flush_valid", 32'(op_valid), 32'd0);
    check("hs_count", 32'(got.size() - got_base), 32'd1);
    check("hs_op", got[got_base], {16'hC305, 16'h0008});
    tick();
    check("hs_e1_valid", 32'(op_valid), 32'd0);
    tick();
    build_model(16'h0040, 1);
    check("hs_e2_valid", 32'(op_valid), 32'd1);
    check("hs_e2_head", {op, op_pc}, exp_q[0]);

    // Asynchronous reset in the middle of a high-byte transfer.
    fixed_wait = 3;
    load_pc(16'h0100);
    k = 0;
    while (!(mem_req && mem_addr == 16'h0101) && k < 40) begin
      tick();
      k++;
    end
    check("hi_reached", 32'(mem_req && mem_addr == 16'h0101), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_op_valid", 32'(op_valid), 32'd0);
    check("arst_op", 32'(op), 32'd0);
    check("arst_op_pc", 32'(op_pc), 32'd0);
    check("arst_halted", 32'(halted), 32'd0);
    fixed_wait = 0;
    tick();
    tick();
    rst_n    = 1'b1;
    got_base = got.size();
    tick();
    check("rerun_req", 32'(mem_req), 32'd1);
    check("rerun_addr", 32'(mem_addr), 32'h0006);
    wait_halt("rerun_halt", 40);
    repeat (3) tick();
    build_model(16'h0006, 8);
    check("rerun_count", 32'(got.size() - got_base), 32'(exp_q.size()));
    check_stream("rerun", got_base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
